// File: rtl/sc_init_seq.sv
// sc_init_seq: walks a register-init ROM table onto the serial-control master and arbitrates the host path.
// Define SC_READBACK_EN to add the VERIFY opcode (8'h03); without it 8'h03 is illegal.
module sc_init_seq #(
    parameter int TBL_AW = 8,
    parameter int TMO_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_go,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,
    input  logic [15:0]       h_subaddr,
    input  logic [7:0]        h_w_data,
    input  logic              h_wr,
    input  logic              h_start,
    output logic              h_busy,
    output logic              h_done,
    output logic [7:0]        h_r_data,
    output logic [15:0]       sc_subaddr,
    output logic [7:0]        sc_w_data,
    output logic              sc_wr,
    output logic              sc_start,
    input  logic              sc_done,
    input  logic [7:0]        sc_r_data,
    output logic              init_busy,
    output logic              init_done,
    output logic              init_err,
    output logic [TBL_AW-1:0] err_addr
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, HOST_ISSUE, HOST_WAIT, DONE, ERR
    } state_t;

    localparam logic [TBL_AW-1:0] LAST_ADDR = '1;
    // Last waiting cycle that may still see sc_done; the wait lasts 2^TMO_W-1 cycles at most.
    localparam logic [TMO_W-1:0]  TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t state, state_n;
    logic [TMO_W-1:0] tmo;
    logic [15:0] dly;
    logic [15:0] hq_subaddr;
    logic [7:0] hq_w_data;
    logic hq_wr;
    logic arb, go, host_go, adv, fail, h_fin, chk_fail;
    logic [7:0] op;
    logic op_end, op_wr, op_dly, op_ver;

    assign op       = tbl_data[31:24];
    assign op_end   = op == 8'h00;
    assign op_wr    = op == 8'h01;
    assign op_dly   = op == 8'h02;
    assign arb      = state == IDLE || state == DONE || state == ERR;
    assign go       = arb && init_go;
    assign host_go  = arb && !init_go && h_busy;
    assign sc_start = state == ISSUE || state == HOST_ISSUE;

`ifdef SC_READBACK_EN
    logic [7:0] exp_data;
    logic rd_chk;
    assign op_ver   = op == 8'h03;
    assign chk_fail = rd_chk && sc_r_data != exp_data;
    // Hold the expected readback of a VERIFY entry until its sc_done arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_data <= '0;
            rd_chk   <= 1'b0;
        end else if (state == DECODE) begin
            exp_data <= tbl_data[7:0];
            rd_chk   <= op_ver;
        end
    end
`else
    assign op_ver   = 1'b0;
    assign chk_fail = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    // Next state plus one-cycle strobes: adv = entry finished, fail = abort at tbl_addr, h_fin = host finished.
    always_comb begin
        state_n = state;
        adv     = 1'b0;
        fail    = 1'b0;
        h_fin   = 1'b0;
        case (state)
            IDLE, DONE, ERR: state_n = go ? FETCH : host_go ? HOST_ISSUE : state;
            FETCH:           state_n = DECODE;
            DECODE: begin
                if (op_end) state_n = DONE;
                else if (op_wr || op_ver) state_n = ISSUE;
                else if (op_dly) begin
                    state_n = DELAY;
                    adv     = tbl_data[15:0] == 16'd0;
                end else fail = 1'b1;
            end
            ISSUE:           state_n = WAIT_DONE;
            WAIT_DONE: begin
                adv  = sc_done && !chk_fail;
                fail = sc_done ? chk_fail : tmo == TMO_LAST;
            end
            DELAY:           adv = dly == 16'd0;
            HOST_ISSUE:      state_n = HOST_WAIT;
            HOST_WAIT: begin
                h_fin   = sc_done || tmo == TMO_LAST;
                state_n = h_fin ? IDLE : HOST_WAIT;
            end
            default:         state_n = IDLE;
        endcase
        if (adv) state_n = tbl_addr == LAST_ADDR ? ERR : FETCH;
        if (fail) state_n = ERR;
    end

    // Counters, host pending slot, master-facing fields and sticky init status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo        <= '0;
            dly        <= '0;
            hq_subaddr <= '0;
            hq_w_data  <= '0;
            hq_wr      <= 1'b0;
            tbl_addr   <= '0;
            h_busy     <= 1'b0;
            h_done     <= 1'b0;
            h_r_data   <= '0;
            sc_subaddr <= '0;
            sc_w_data  <= '0;
            sc_wr      <= 1'b0;
            init_busy  <= 1'b0;
            init_done  <= 1'b0;
            init_err   <= 1'b0;
            err_addr   <= '0;
        end else begin
            tmo    <= (state == WAIT_DONE || state == HOST_WAIT) ? tmo + 1'b1 : '0;
            dly    <= state == DECODE ? tbl_data[15:0] - 16'd1 : state == DELAY ? dly - 16'd1 : dly;
            h_done <= h_fin;
            if (h_fin) begin
                h_busy   <= 1'b0;
                h_r_data <= sc_done ? sc_r_data : 8'hFF;
            end else if (h_start && !h_busy) begin
                h_busy     <= 1'b1;
                hq_subaddr <= h_subaddr;
                hq_w_data  <= h_w_data;
                hq_wr      <= h_wr;
            end
            if (host_go) begin
                sc_subaddr <= hq_subaddr;
                sc_w_data  <= hq_w_data;
                sc_wr      <= hq_wr;
            end else if (state == DECODE && (op_wr || op_ver)) begin
                sc_subaddr <= tbl_data[23:8];
                sc_w_data  <= tbl_data[7:0];
                sc_wr      <= op_wr;
            end
            if (go) begin
                tbl_addr  <= '0;
                init_busy <= 1'b1;
                init_done <= 1'b0;
                init_err  <= 1'b0;
                err_addr  <= '0;
            end
            if (state == DECODE && op_end) begin
                init_done <= 1'b1;
                init_busy <= 1'b0;
            end
            if (adv && tbl_addr != LAST_ADDR) tbl_addr <= tbl_addr + 1'b1;
            if (fail || (adv && tbl_addr == LAST_ADDR)) begin
                init_err  <= 1'b1;
                init_busy <= 1'b0;
                err_addr  <= tbl_addr;
            end
        end
    end
endmodule
